// File: rtl/prog_fsm_pkg.sv
// Shared types and helpers for the programmable Moore machine.
// Covers config-select decoding, counter width and transition-table addressing.
package prog_fsm_pkg;

   typedef enum logic [1:0] {
      CFG_TRANS = 2'd0,
      CFG_OUT   = 2'd1,
      CFG_INIT  = 2'd2,
      CFG_RSVD  = 2'd3
   } cfg_sel_e;

   localparam int STEP_CNT_W = 16;

   // Transition entries are laid out as {state, sym}, so one state's row is contiguous.
   function automatic int transAddr(input int stateIdx, input int sym, input int inW);
      return (stateIdx << inW) | sym;
   endfunction

   function automatic logic stateLegal(input int stateIdx, input int numStates);
      return stateIdx < numStates;
   endfunction

endpackage

// File: rtl/prog_fsm_table.sv
// Flop-based transition and output tables with one write port and two read ports.
// Reads are combinational, so a same-edge write is only seen from the next cycle.
module prog_fsm_table
   import prog_fsm_pkg::*;
#(
   parameter int NUM_STATES = 4,
   parameter int IN_W       = 2,
   parameter int OUT_W      = 1,
   parameter int SW         = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             transWe_i,
   input  logic [SW-1:0]    transWrState_i,
   input  logic [IN_W-1:0]  transWrSym_i,
   input  logic [SW-1:0]    transWrNext_i,
   input  logic             outWe_i,
   input  logic [SW-1:0]    outWrState_i,
   input  logic [OUT_W-1:0] outWrData_i,
   input  logic [SW-1:0]    rdState_i,
   input  logic [IN_W-1:0]  rdSym_i,
   output logic [SW-1:0]    rdNext_o,
   input  logic [SW-1:0]    outState_i,
   output logic [OUT_W-1:0] outData_o
);

   localparam int ADDR_W  = SW + IN_W;
   localparam int TRANS_N = 2 ** ADDR_W;
   localparam int STATE_N = 2 ** SW;

   logic [SW-1:0]    trans_q  [TRANS_N];
   logic [OUT_W-1:0] outTbl_q [STATE_N];
   logic [ADDR_W-1:0] wrAddr;
   logic [ADDR_W-1:0] rdAddr;

   assign wrAddr = ADDR_W'(transAddr(int'(transWrState_i), int'(transWrSym_i), IN_W));
   assign rdAddr = ADDR_W'(transAddr(int'(rdState_i), int'(rdSym_i), IN_W));

   // Reset turns every state into a pure self-loop with a zero output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TRANS_N; i++) begin
            trans_q[i] <= SW'(i >> IN_W);
         end
         for (int i = 0; i < STATE_N; i++) begin
            outTbl_q[i] <= '0;
         end
      end else begin
         if (transWe_i) begin
            trans_q[wrAddr] <= transWrNext_i;
         end
         if (outWe_i) begin
            outTbl_q[outWrState_i] <= outWrData_i;
         end
      end
   end

   assign rdNext_o  = trans_q[rdAddr];
   assign outData_o = stateLegal(int'(outState_i), NUM_STATES) ? outTbl_q[outState_i] : '0;

endmodule

// File: rtl/prog_moore_fsm.sv
// Table-driven programmable Moore machine: state, init register, step counter and config error.
// Define PROG_FSM_CFG_CHECK_EN to drop out-of-range config writes and raise a sticky cfg_err.
module prog_moore_fsm
   import prog_fsm_pkg::*;
#(
   parameter int  NUM_STATES = 4,
   parameter int  IN_W       = 2,
   parameter int  OUT_W      = 1,
   parameter int  INIT_STATE = 0,
   localparam int SW         = ($clog2(NUM_STATES) > 1) ? $clog2(NUM_STATES) : 1,
   localparam int WD         = (SW > OUT_W) ? SW : OUT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  step,
   input  logic [IN_W-1:0]       sym_in,
   input  logic                  restart,
   input  logic                  cfg_we,
   input  logic [1:0]            cfg_sel,
   input  logic [SW+IN_W-1:0]    cfg_addr,
   input  logic [WD-1:0]         cfg_wdata,
   output logic [SW-1:0]         state,
   output logic [OUT_W-1:0]      out,
   output logic [STEP_CNT_W-1:0] step_cnt,
   output logic                  cfg_err
);

   cfg_sel_e             selE;
   logic [SW-1:0]        state_q, state_d;
   logic [SW-1:0]        init_q;
   logic [OUT_W-1:0]     out_q;
   logic [STEP_CNT_W-1:0] cnt_q;
   logic                 err_q;
   logic [SW-1:0]        transWrState;
   logic [SW-1:0]        outWrState;
   logic [SW-1:0]        transRd;
   logic [OUT_W-1:0]     outRd;
   logic                 transOk, outOk, initOk;
   logic                 transWe, outWe, initWe, badWr;

   assign selE         = cfg_sel_e'(cfg_sel);
   assign transWrState = cfg_addr[SW+IN_W-1:IN_W];
   assign outWrState   = cfg_addr[SW-1:0];

`ifdef PROG_FSM_CFG_CHECK_EN
   assign transOk = stateLegal(int'(transWrState), NUM_STATES) && stateLegal(int'(cfg_wdata), NUM_STATES);
   assign outOk   = stateLegal(int'(outWrState), NUM_STATES);
   assign initOk  = stateLegal(int'(cfg_wdata), NUM_STATES);
`else
   assign transOk = 1'b1;
   assign outOk   = 1'b1;
   assign initOk  = 1'b1;
`endif

   assign transWe = cfg_we && (selE == CFG_TRANS) && transOk;
   assign outWe   = cfg_we && (selE == CFG_OUT) && outOk;
   assign initWe  = cfg_we && (selE == CFG_INIT) && initOk;
   assign badWr   = cfg_we && (((selE == CFG_TRANS) && !transOk) ||
                               ((selE == CFG_OUT) && !outOk) ||
                               ((selE == CFG_INIT) && !initOk));

   prog_fsm_table #(
      .NUM_STATES (NUM_STATES),
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .SW         (SW)
   ) u_table (
      .clk            (clk),
      .reset          (reset),
      .transWe_i      (transWe),
      .transWrState_i (transWrState),
      .transWrSym_i   (cfg_addr[IN_W-1:0]),
      .transWrNext_i  (cfg_wdata[SW-1:0]),
      .outWe_i        (outWe),
      .outWrState_i   (outWrState),
      .outWrData_i    (cfg_wdata[OUT_W-1:0]),
      .rdState_i      (state_q),
      .rdSym_i        (sym_in),
      .rdNext_o       (transRd),
      .outState_i     (state_d),
      .outData_o      (outRd)
   );

   // An illegal current state has no valid row, so stepping out of it falls back to init.
   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = init_q;
      end else if (step) begin
         state_d = stateLegal(int'(state_q), NUM_STATES) ? transRd : init_q;
      end
   end

   // The output is looked up with the next state, so it changes on the same edge as state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SW'(INIT_STATE);
         init_q  <= SW'(INIT_STATE);
         out_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= outRd;
         if (restart) begin
            cnt_q <= '0;
            err_q <= 1'b0;
         end else begin
            if (step && (cnt_q != '1)) begin
               cnt_q <= cnt_q + 1'b1;
            end
            if (badWr) begin
               err_q <= 1'b1;
            end
         end
         if (initWe) begin
            init_q <= cfg_wdata[SW-1:0];
         end
      end
   end

   assign state    = state_q;
   assign out      = out_q;
   assign step_cnt = cnt_q;
   assign cfg_err  = err_q;

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Directed bench for prog_moore_fsm: a 2-state instance for the main behaviour
// and a 3-state instance for illegal-state handling (with or without PROG_FSM_CFG_CHECK_EN).
module tb_prog_moore_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        step = 1'b0;
   logic [1:0]  symIn = '0;
   logic        restart = 1'b0;
   logic        cfgWe = 1'b0;
   logic [1:0]  cfgSel = '0;
   logic [2:0]  cfgAddr = '0;
   logic [0:0]  cfgWdata = '0;
   logic [0:0]  state;
   logic [0:0]  outp;
   logic [15:0] stepCnt;
   logic        cfgErr;

   logic        n3Step = 1'b0;
   logic [1:0]  n3Sym = '0;
   logic        n3Restart = 1'b0;
   logic        n3We = 1'b0;
   logic [1:0]  n3Sel = '0;
   logic [3:0]  n3Addr = '0;
   logic [1:0]  n3Wdata = '0;
   logic [1:0]  n3State;
   logic [0:0]  n3Out;
   logic [15:0] n3Cnt;
   logic        n3Err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   prog_moore_fsm #(.NUM_STATES(2), .IN_W(2), .OUT_W(1), .INIT_STATE(0)) dut (
      .clk(clk), .reset(reset), .step(step), .sym_in(symIn), .restart(restart),
      .cfg_we(cfgWe), .cfg_sel(cfgSel), .cfg_addr(cfgAddr), .cfg_wdata(cfgWdata),
      .state(state), .out(outp), .step_cnt(stepCnt), .cfg_err(cfgErr)
   );

   prog_moore_fsm #(.NUM_STATES(3), .IN_W(2), .OUT_W(1), .INIT_STATE(0)) dut3 (
      .clk(clk), .reset(reset), .step(n3Step), .sym_in(n3Sym), .restart(n3Restart),
      .cfg_we(n3We), .cfg_sel(n3Sel), .cfg_addr(n3Addr), .cfg_wdata(n3Wdata),
      .state(n3State), .out(n3Out), .step_cnt(n3Cnt), .cfg_err(n3Err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wrTrans(input logic s, input logic [1:0] x, input logic n);
      cfgWe = 1'b1; cfgSel = 2'd0; cfgAddr = {s, x}; cfgWdata = n;
      tick();
      cfgWe = 1'b0;
   endtask

   task automatic wrOut(input logic s, input logic v);
      cfgWe = 1'b1; cfgSel = 2'd1; cfgAddr = {2'b00, s}; cfgWdata = v;
      tick();
      cfgWe = 1'b0;
   endtask

   task automatic wrInit(input logic v);
      cfgWe = 1'b1; cfgSel = 2'd2; cfgAddr = '0; cfgWdata = v;
      tick();
      cfgWe = 1'b0;
   endtask

   task automatic stepSym(input logic [1:0] x);
      step = 1'b1; symIn = x;
      tick();
      step = 1'b0;
   endtask

   task automatic wr3(input logic [1:0] sel, input logic [3:0] addr, input logic [1:0] data);
      n3We = 1'b1; n3Sel = sel; n3Addr = addr; n3Wdata = data;
      tick();
      n3We = 1'b0;
   endtask

   task automatic step3(input logic [1:0] x);
      n3Step = 1'b1; n3Sym = x;
      tick();
      n3Step = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++; if (state !== 1'b0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
      checks++; if (outp !== 1'b0) begin failures++; $display("[TB] FAIL reset_out got=%0d exp=0", outp); end
      checks++; if (stepCnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", stepCnt); end
      checks++; if (cfgErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0d exp=0", cfgErr); end
      checks++; if (n3State !== 2'd0) begin failures++; $display("[TB] FAIL reset_state3 got=%0d exp=0", n3State); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_program();
      logic [1:0] syms [3] = '{2'd1, 2'd2, 2'd3};
      logic       expS [3] = '{1'b1, 1'b1, 1'b0};
      applyReset();
      wrTrans(1'b0, 2'd0, 1'b0); wrTrans(1'b0, 2'd1, 1'b1);
      wrTrans(1'b0, 2'd2, 1'b1); wrTrans(1'b0, 2'd3, 1'b1);
      wrTrans(1'b1, 2'd0, 1'b1); wrTrans(1'b1, 2'd1, 1'b0);
      wrTrans(1'b1, 2'd2, 1'b1); wrTrans(1'b1, 2'd3, 1'b0);
      wrOut(1'b0, 1'b0); wrOut(1'b1, 1'b1);
      checks++; if (outp !== 1'b0) begin failures++; $display("[TB] FAIL prog_idle_out got=%0d exp=0", outp); end
      for (int i = 0; i < 3; i++) begin
         stepSym(syms[i]);
         checks++; if (state !== expS[i]) begin failures++; $display("[TB] FAIL prog_state[%0d] got=%0d exp=%0d", i, state, expS[i]); end
         checks++; if (outp !== expS[i]) begin failures++; $display("[TB] FAIL prog_out[%0d] got=%0d exp=%0d", i, outp, expS[i]); end
      end
      checks++; if (stepCnt !== 16'd3) begin failures++; $display("[TB] FAIL prog_cnt got=%0d exp=3", stepCnt); end
   endtask

   task automatic test_self_loops();
      applyReset();
      repeat (5) stepSym(2'd3);
      checks++; if (state !== 1'b0) begin failures++; $display("[TB] FAIL loop_state got=%0d exp=0", state); end
      checks++; if (outp !== 1'b0) begin failures++; $display("[TB] FAIL loop_out got=%0d exp=0", outp); end
      checks++; if (stepCnt !== 16'd5) begin failures++; $display("[TB] FAIL loop_cnt got=%0d exp=5", stepCnt); end
   endtask

   task automatic test_back_to_back();
      applyReset();
      wrTrans(1'b0, 2'd1, 1'b1);
      step = 1'b1; symIn = 2'd1;
      cfgWe = 1'b1; cfgSel = 2'd0; cfgAddr = {1'b0, 2'd1}; cfgWdata = 1'b0;
      tick();
      step = 1'b0; cfgWe = 1'b0;
      checks++; if (state !== 1'b1) begin failures++; $display("[TB] FAIL b2b_old_entry got=%0d exp=1", state); end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++; if (stepCnt !== 16'd0) begin failures++; $display("[TB] FAIL b2b_restart_cnt got=%0d exp=0", stepCnt); end
      stepSym(2'd1);
      checks++; if (state !== 1'b0) begin failures++; $display("[TB] FAIL b2b_new_entry got=%0d exp=0", state); end
      checks++; if (stepCnt !== 16'd1) begin failures++; $display("[TB] FAIL b2b_cnt got=%0d exp=1", stepCnt); end
   endtask

   task automatic test_init_restart();
      applyReset();
      wrOut(1'b1, 1'b1);
      wrInit(1'b1);
      checks++; if (state !== 1'b0) begin failures++; $display("[TB] FAIL init_no_move got=%0d exp=0", state); end
      cfgWe = 1'b1; cfgSel = 2'd3; cfgAddr = '0; cfgWdata = 1'b0;
      tick();
      cfgWe = 1'b0;
      stepSym(2'd2);
      restart = 1'b1; step = 1'b1; symIn = 2'd0;
      tick();
      restart = 1'b0; step = 1'b0;
      checks++; if (state !== 1'b1) begin failures++; $display("[TB] FAIL init_restart_state got=%0d exp=1", state); end
      checks++; if (outp !== 1'b1) begin failures++; $display("[TB] FAIL init_restart_out got=%0d exp=1", outp); end
      checks++; if (stepCnt !== 16'd0) begin failures++; $display("[TB] FAIL init_restart_cnt got=%0d exp=0", stepCnt); end
      stepSym(2'd0);
      stepSym(2'd0);
      #2;
      reset = 1'b1;
      #2;
      checks++; if (state !== 1'b0) begin failures++; $display("[TB] FAIL async_state got=%0d exp=0", state); end
      checks++; if (outp !== 1'b0) begin failures++; $display("[TB] FAIL async_out got=%0d exp=0", outp); end
      checks++; if (stepCnt !== 16'd0) begin failures++; $display("[TB] FAIL async_cnt got=%0d exp=0", stepCnt); end
      reset = 1'b0;
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++; if (state !== 1'b0) begin failures++; $display("[TB] FAIL async_init_reg got=%0d exp=0", state); end
   endtask

   task automatic test_saturation();
      applyReset();
      step = 1'b1; symIn = 2'd0;
      repeat (65534) tick();
      step = 1'b0;
      checks++; if (stepCnt !== 16'hFFFE) begin failures++; $display("[TB] FAIL sat_pre got=%h exp=fffe", stepCnt); end
      stepSym(2'd0);
      checks++; if (stepCnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_first got=%h exp=ffff", stepCnt); end
      stepSym(2'd0);
      stepSym(2'd0);
      checks++; if (stepCnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_hold got=%h exp=ffff", stepCnt); end
   endtask

   task automatic test_illegal_state();
      logic       expErr;
      logic [1:0] expAfter1;
      logic [1:0] expAfter2;
      logic       expOut2;
`ifdef PROG_FSM_CFG_CHECK_EN
      expErr = 1'b1; expAfter1 = 2'd0; expAfter2 = 2'd0; expOut2 = 1'b0;
`else
      expErr = 1'b0; expAfter1 = 2'd3; expAfter2 = 2'd2; expOut2 = 1'b1;
`endif
      applyReset();
      wr3(2'd2, 4'd0, 2'd2);
      wr3(2'd1, 4'd2, 2'd1);
      wr3(2'd0, 4'b0001, 2'd3);
      checks++; if (n3Err !== expErr) begin failures++; $display("[TB] FAIL ill_err got=%0d exp=%0d", n3Err, expErr); end
      step3(2'd1);
      checks++; if (n3State !== expAfter1) begin failures++; $display("[TB] FAIL ill_step1 got=%0d exp=%0d", n3State, expAfter1); end
      checks++; if (n3Out !== 1'b0) begin failures++; $display("[TB] FAIL ill_out1 got=%0d exp=0", n3Out); end
      step3(2'd0);
      checks++; if (n3State !== expAfter2) begin failures++; $display("[TB] FAIL ill_step2 got=%0d exp=%0d", n3State, expAfter2); end
      checks++; if (n3Out !== expOut2) begin failures++; $display("[TB] FAIL ill_out2 got=%0d exp=%0d", n3Out, expOut2); end
      checks++; if (n3Err !== expErr) begin failures++; $display("[TB] FAIL ill_err_sticky got=%0d exp=%0d", n3Err, expErr); end
      n3Restart = 1'b1;
      tick();
      n3Restart = 1'b0;
      checks++; if (n3Err !== 1'b0) begin failures++; $display("[TB] FAIL ill_err_clear got=%0d exp=0", n3Err); end
      checks++; if (n3State !== 2'd2) begin failures++; $display("[TB] FAIL ill_restart_state got=%0d exp=2", n3State); end
      checks++; if (n3Out !== 1'b1) begin failures++; $display("[TB] FAIL ill_restart_out got=%0d exp=1", n3Out); end
   endtask

   initial begin
      test_reset();
      test_program();
      test_self_loops();
      test_back_to_back();
      test_init_restart();
      test_saturation();
      test_illegal_state();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
